// File: rtl/control_rampa_pwm.sv
`default_nettype none
// ============================================================================
// control_rampa_pwm : soft-start duty slew controller and PWM period counter
// Rev 1.0
// ============================================================================
module control_rampa_pwm #(
  parameter int unsigned ANCHO   = 10,
  parameter int unsigned PERIODO = 1000,
  parameter int unsigned PASO    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             habilitar,
  input  logic [ANCHO-1:0] cuenta_objetivo,
  output logic [ANCHO-1:0] contador_clk,
  output logic [ANCHO-1:0] cuenta_max,
  output logic             fin_periodo,
  output logic             en_objetivo,
  output logic [1:0]       estado
);

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    RAMPA    = 2'b01,
    ESTABLE  = 2'b10,
    DESCARGA = 2'b11
  } estado_t;

  localparam logic [ANCHO-1:0] c_PERIODO  = ANCHO'(PERIODO);
  localparam logic [ANCHO-1:0] c_ULTIMO   = ANCHO'(PERIODO - 1);
  localparam logic [ANCHO-1:0] c_PASO     = ANCHO'(PASO);
  localparam logic [ANCHO:0]   c_PASO_EXT = (ANCHO+1)'(PASO);

  estado_t          r_estado,      w_estado_sig;
  logic [ANCHO-1:0] r_contador,    w_contador_sig;
  logic [ANCHO-1:0] r_cuenta_max,  w_cuenta_max_sig;
  logic [ANCHO-1:0] r_objetivo_lat, w_objetivo_lat_sig;
  logic             r_en_objetivo;

  logic             w_fin;
  logic [ANCHO-1:0] w_objetivo_clamp;
  logic [ANCHO-1:0] w_objetivo;
  logic [ANCHO-1:0] w_destino;
  logic             w_sube;
  logic [ANCHO:0]   w_dif;
  logic [ANCHO-1:0] w_slew;

  assign w_fin            = (r_estado != REPOSO) && (r_contador == c_ULTIMO);
  assign w_objetivo_clamp = (cuenta_objetivo > c_PERIODO) ? c_PERIODO : cuenta_objetivo;
  // The live input is only trusted in the boundary cycle; elsewhere the latch stands in.
  assign w_objetivo       = w_fin ? w_objetivo_clamp : r_objetivo_lat;
  assign w_destino        = habilitar ? w_objetivo : '0;

  assign w_sube = (w_destino > r_cuenta_max);
  assign w_dif  = w_sube ? ({1'b0, w_destino} - {1'b0, r_cuenta_max})
                         : ({1'b0, r_cuenta_max} - {1'b0, w_destino});
  // A full step cannot overshoot here because the remaining distance exceeds PASO.
  assign w_slew = (w_dif <= c_PASO_EXT) ? w_destino
                : (w_sube ? (r_cuenta_max + c_PASO) : (r_cuenta_max - c_PASO));

  always_comb begin
    w_estado_sig       = r_estado;
    w_contador_sig     = r_contador;
    w_cuenta_max_sig   = r_cuenta_max;
    w_objetivo_lat_sig = r_objetivo_lat;

    if (w_fin) begin
      w_objetivo_lat_sig = w_objetivo_clamp;
    end

    case (r_estado)
      REPOSO: begin
        w_contador_sig   = '0;
        w_cuenta_max_sig = '0;
        if (habilitar) begin
          w_estado_sig = RAMPA;
        end
      end
      RAMPA, ESTABLE: begin
        w_contador_sig = w_fin ? '0 : (r_contador + ANCHO'(1));
        if (w_fin) begin
          w_cuenta_max_sig = w_slew;
          if (!habilitar) begin
            w_estado_sig = DESCARGA;
          end else if (w_slew == w_destino) begin
            w_estado_sig = ESTABLE;
          end else begin
            w_estado_sig = RAMPA;
          end
        end
      end
      default: begin
        w_contador_sig = w_fin ? '0 : (r_contador + ANCHO'(1));
        if (w_fin) begin
          w_cuenta_max_sig = w_slew;
          if (habilitar) begin
            w_estado_sig = RAMPA;
          end else if (w_slew == '0) begin
            w_estado_sig = REPOSO;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado       <= REPOSO;
      r_contador     <= '0;
      r_cuenta_max   <= '0;
      r_objetivo_lat <= '0;
      r_en_objetivo  <= 1'b0;
    end else begin
      r_estado       <= w_estado_sig;
      r_contador     <= w_contador_sig;
      r_cuenta_max   <= w_cuenta_max_sig;
      r_objetivo_lat <= w_objetivo_lat_sig;
      r_en_objetivo  <= (w_estado_sig == ESTABLE);
    end
  end

  assign contador_clk = r_contador;
  assign cuenta_max   = r_cuenta_max;
  assign fin_periodo  = w_fin;
  assign en_objetivo  = r_en_objetivo;
  assign estado       = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_control_rampa_pwm.sv
`default_nettype none
// ============================================================================
// tb_control_rampa_pwm : directed table-driven bench for control_rampa_pwm
// Rev 1.0
// ============================================================================
module tb_control_rampa_pwm;

  localparam int ANCHO   = 10;
  localparam int PERIODO = 10;
  localparam int PASO    = 3;

  logic             clk;
  logic             reset;
  logic             habilitar;
  logic [ANCHO-1:0] cuenta_objetivo;
  logic [ANCHO-1:0] contador_clk;
  logic [ANCHO-1:0] cuenta_max;
  logic             fin_periodo;
  logic             en_objetivo;
  logic [1:0]       estado;

  control_rampa_pwm #(.ANCHO(ANCHO), .PERIODO(PERIODO), .PASO(PASO)) dut (
    .clk             (clk),
    .reset           (reset),
    .habilitar       (habilitar),
    .cuenta_objetivo (cuenta_objetivo),
    .contador_clk    (contador_clk),
    .cuenta_max      (cuenta_max),
    .fin_periodo     (fin_periodo),
    .en_objetivo     (en_objetivo),
    .estado          (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             hab;
    logic [ANCHO-1:0] obj;
    logic [ANCHO-1:0] cm;
    logic [1:0]       st;
    logic             en;
  } vec_t;

  vec_t tabla [0:14];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nombre, input int actual, input int requerido);
    checks++;
    if (actual != requerido) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nombre, actual, requerido);
    end
  endtask

  task automatic wait_boundary();
    bit ok = 1'b0;
    for (int n = 0; n < 4*PERIODO && !ok; n++) begin
      @(negedge clk);
      if (fin_periodo) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL boundary_timeout actual=no_fin required=fin_periodo");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_count(input int valor);
    bit ok = 1'b0;
    for (int n = 0; n < 4*PERIODO && !ok; n++) begin
      @(negedge clk);
      if (int'(contador_clk) == valor) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL count_timeout actual=%0d required=%0d", contador_clk, valor);
    end
  endtask

  task automatic chk_zeros(input string nombre);
    chk({nombre, "_contador"}, int'(contador_clk), 0);
    chk({nombre, "_cuenta_max"}, int'(cuenta_max), 0);
    chk({nombre, "_fin"}, int'(fin_periodo), 0);
    chk({nombre, "_en"}, int'(en_objetivo), 0);
    chk({nombre, "_estado"}, int'(estado), 0);
  endtask

  task automatic apply_rows(input int primero, input int ultimo);
    for (int i = primero; i <= ultimo; i++) begin
      habilitar       = tabla[i].hab;
      cuenta_objetivo = tabla[i].obj;
      wait_boundary();
      chk($sformatf("row%0d_cuenta_max", i), int'(cuenta_max), int'(tabla[i].cm));
      chk($sformatf("row%0d_estado", i), int'(estado), int'(tabla[i].st));
      chk($sformatf("row%0d_en", i), int'(en_objetivo), int'(tabla[i].en));
      chk($sformatf("row%0d_contador", i), int'(contador_clk), 0);
    end
  endtask

  initial begin
    int malos;
    int altos;

    // Ramp up 0->8, hold, disable/re-enable, discharge to idle, then clamp to 100%.
    tabla[0]  = '{1'b1, 10'd8,    10'd3,  2'b01, 1'b0};
    tabla[1]  = '{1'b1, 10'd8,    10'd6,  2'b01, 1'b0};
    tabla[2]  = '{1'b1, 10'd8,    10'd8,  2'b10, 1'b1};
    tabla[3]  = '{1'b1, 10'd8,    10'd8,  2'b10, 1'b1};
    tabla[4]  = '{1'b0, 10'd8,    10'd5,  2'b11, 1'b0};
    tabla[5]  = '{1'b1, 10'd8,    10'd8,  2'b01, 1'b0};
    tabla[6]  = '{1'b1, 10'd8,    10'd8,  2'b10, 1'b1};
    tabla[7]  = '{1'b0, 10'd8,    10'd5,  2'b11, 1'b0};
    tabla[8]  = '{1'b0, 10'd8,    10'd2,  2'b11, 1'b0};
    tabla[9]  = '{1'b0, 10'd8,    10'd0,  2'b00, 1'b0};
    tabla[10] = '{1'b1, 10'd1023, 10'd3,  2'b01, 1'b0};
    tabla[11] = '{1'b1, 10'd1023, 10'd6,  2'b01, 1'b0};
    tabla[12] = '{1'b1, 10'd1023, 10'd9,  2'b01, 1'b0};
    tabla[13] = '{1'b1, 10'd1023, 10'd10, 2'b10, 1'b1};
    tabla[14] = '{1'b1, 10'd1023, 10'd10, 2'b10, 1'b1};

    reset           = 1'b1;
    habilitar       = 1'b0;
    cuenta_objetivo = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zeros("reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_without_enable", int'(estado), 0);

    habilitar       = 1'b1;
    cuenta_objetivo = 10'd8;
    @(posedge clk);
    #1;
    chk("enable_estado", int'(estado), 1);
    chk("enable_contador", int'(contador_clk), 0);
    chk("enable_cuenta_max", int'(cuenta_max), 0);

    apply_rows(0, 3);

    // Target glitches inside a period must not be sampled.
    wait_count(4);
    cuenta_objetivo = 10'd2;
    wait_count(8);
    cuenta_objetivo = 10'd8;
    chk("midperiod_cuenta_max", int'(cuenta_max), 8);
    wait_boundary();
    chk("midperiod_boundary_cm", int'(cuenta_max), 8);
    chk("midperiod_boundary_estado", int'(estado), 2);
    chk("midperiod_boundary_en", int'(en_objetivo), 1);

    apply_rows(4, 9);

    malos = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (contador_clk != '0 || fin_periodo || estado != 2'b00) malos++;
    end
    chk("reposo_hold_bad_cycles", malos, 0);

    habilitar       = 1'b1;
    cuenta_objetivo = 10'd1023;
    @(posedge clk);
    #1;
    chk("clamp_enable_estado", int'(estado), 1);

    apply_rows(10, 14);

    altos = 0;
    for (int n = 0; n < PERIODO; n++) begin
      @(negedge clk);
      if (contador_clk < cuenta_max) altos++;
    end
    chk("pwm_full_high_cycles", altos, PERIODO);

    // Fresh start, then asynchronous reset at count 6 of RAMPA.
    @(negedge clk);
    reset           = 1'b0;
    cuenta_objetivo = 10'd8;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_estado", int'(estado), 1);
    apply_rows(0, 1);
    wait_count(6);
    reset = 1'b0;
    #1;
    chk_zeros("async_reset");
    habilitar = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("post_reset_estado", int'(estado), 0);
    chk("post_reset_contador", int'(contador_clk), 0);
    habilitar = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_enable_estado", int'(estado), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
